dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 148 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter sharing a single-port data memory between the CPU
// load/store port (r0) and the loader/debug port (r1), with locked bursts.
module dmem_arbiter #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic              r0_lock,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_rvalid,
    input  logic              r1_req,
    input  logic              r1_lock,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W    = 8;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
    localparam bit          BURST_EN = (MAX_BURST > 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rvalid0_q, rvalid1_q;
    logic             g0, g1;

    // State, pointer, counter and read-valid registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            rvalid0_q <= r0_gnt & ~r0_we;
            rvalid1_q <= r1_gnt & ~r1_we;
        end
    end

    // Grant selection and next-state logic
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        g0      = 1'b0;
        g1      = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Tie goes to whichever requester was not granted last
                if (r0_req && (!r1_req || last_q)) begin
                    g0 = 1'b1;
                end else if (r1_req) begin
                    g1 = 1'b1;
                end
                if (g0 || g1) begin
                    last_d = g1;
                    if (BURST_EN && (g1 ? r1_lock : r0_lock)) begin
                        state_d = g1 ? OWN1 : OWN0;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            OWN0: begin
                if (r0_req) begin
                    g0     = 1'b1;
                    last_d = 1'b0;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (!r0_lock || cnt_d >= MAX_CNT) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (!r0_lock) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            OWN1: begin
                if (r1_req) begin
                    g1     = 1'b1;
                    last_d = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (!r1_lock || cnt_d >= MAX_CNT) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (!r1_lock) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Grants and the memory port are forced quiet while reset is held
    always_comb begin
        r0_gnt    = g0 & rst_n;
        r1_gnt    = g1 & rst_n;
        mem_en    = r0_gnt | r1_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (r0_gnt) begin
            mem_we    = r0_we;
            mem_addr  = r0_addr;
            mem_wdata = r0_wdata;
        end else if (r1_gnt) begin
            mem_we    = r1_we;
            mem_addr  = r1_addr;
            mem_wdata = r1_wdata;
        end
    end

    assign r0_rvalid = rvalid0_q;
    assign r1_rvalid = rvalid1_q;
    assign r0_rdata  = rvalid0_q ? mem_rdata : '0;
    assign r1_rdata  = rvalid1_q ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: round robin, locked bursts, read return,
// write path and asynchronous reset behaviour.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        r0_req, r0_lock, r0_we;
    logic [31:0] r0_addr, r0_wdata, r0_rdata;
    logic        r0_gnt, r0_rvalid;
    logic        r1_req, r1_lock, r1_we;
    logic [31:0] r1_addr, r1_wdata, r1_rdata;
    logic        r1_gnt, r1_rvalid;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks;
    int n_fail;

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MAX_BURST(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .r0_req    (r0_req),
        .r0_lock   (r0_lock),
        .r0_we     (r0_we),
        .r0_addr   (r0_addr),
        .r0_wdata  (r0_wdata),
        .r0_gnt    (r0_gnt),
        .r0_rdata  (r0_rdata),
        .r0_rvalid (r0_rvalid),
        .r1_req    (r1_req),
        .r1_lock   (r1_lock),
        .r1_we     (r1_we),
        .r1_addr   (r1_addr),
        .r1_wdata  (r1_wdata),
        .r1_gnt    (r1_gnt),
        .r1_rdata  (r1_rdata),
        .r1_rvalid (r1_rvalid),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: 0x40 holds 0xDEADBEEF, every other word is 0xC0DE0000 | addr
    logic       pend_rd;
    logic [7:0] pend_a;
    always @(negedge clk) begin
        pend_rd = mem_en && !mem_we;
        pend_a  = mem_addr[7:0];
    end
    always @(posedge clk) begin
        if (pend_rd)
            mem_rdata <= (pend_a == 8'h40) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | 32'(pend_a));
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        r0_req = 0; r0_lock = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
        r1_req = 0; r1_lock = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        mem_rdata = 32'h0;
        idle_inputs();
        rst_n = 1'b0;

        // Outputs quiet under reset even with both requesting
        r0_req = 1; r0_addr = 32'h10;
        r1_req = 1; r1_addr = 32'h20;
        repeat (2) cyc();
        check("rst_gnt0", r0_gnt, 0);
        check("rst_gnt1", r1_gnt, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_rvalid0", r0_rvalid, 0);
        check("rst_rvalid1", r1_rvalid, 0);

        // Round robin between two readers, r0 wins the first tie
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_gnt0", r0_gnt, (i % 2 == 0));
            check("rr_gnt1", r1_gnt, (i % 2 == 1));
            check("rr_addr", mem_addr, (i % 2 == 0) ? 32'h10 : 32'h20);
            check("rr_rvalid0", r0_rvalid, (i > 0) && (i % 2 == 1));
            check("rr_rvalid1", r1_rvalid, (i > 0) && (i % 2 == 0));
            if (i > 0 && i % 2 == 1) check("rr_rdata0", r0_rdata, 32'hC0DE_0010);
            if (i > 0 && i % 2 == 0) check("rr_rdata1", r1_rdata, 32'hC0DE_0020);
            cyc();
        end
        idle_inputs();
        #1;
        check("rr_last_rvalid1", r1_rvalid, 1);
        check("rr_last_rdata1", r1_rdata, 32'hC0DE_0020);
        check("rr_last_rvalid0", r0_rvalid, 0);
        check("rr_last_rdata0", r0_rdata, 0);
        check("nogrant_en", mem_en, 0);
        check("nogrant_addr", mem_addr, 0);

        // Single r1 read returns memory data one cycle later
        cyc();
        r1_req = 1; r1_addr = 32'h40;
        #1;
        check("rd1_gnt1", r1_gnt, 1);
        check("rd1_gnt0", r0_gnt, 0);
        cyc();
        idle_inputs();
        #1;
        check("rd1_rvalid1", r1_rvalid, 1);
        check("rd1_rdata1", r1_rdata, 32'hDEAD_BEEF);
        check("rd1_rvalid0", r0_rvalid, 0);

        // r0 write drives the memory port and produces no rvalid
        cyc();
        r0_req = 1; r0_we = 1; r0_addr = 32'h8; r0_wdata = 32'h55;
        #1;
        check("wr_gnt0", r0_gnt, 1);
        check("wr_en", mem_en, 1);
        check("wr_we", mem_we, 1);
        check("wr_addr", mem_addr, 32'h8);
        check("wr_wdata", mem_wdata, 32'h55);
        cyc();
        idle_inputs();
        #1;
        check("wr_rvalid0", r0_rvalid, 0);

        // Locked r0 burst capped at 8 beats, then r1 gets its turn
        cyc();
        r0_req = 1; r0_lock = 1; r0_addr = 32'h1;
        #1;
        check("burst_beat1", r0_gnt, 1);
        cyc();
        r1_req = 1; r1_addr = 32'h2;
        for (int b = 2; b <= 8; b++) begin
            #1;
            check("burst_gnt0", r0_gnt, 1);
            check("burst_gnt1", r1_gnt, 0);
            cyc();
        end
        #1;
        check("burst_end_gnt1", r1_gnt, 1);
        check("burst_end_gnt0", r0_gnt, 0);
        cyc();
        idle_inputs();

        // r0 drops lock on beat 3; r1 follows despite r0 still requesting
        cyc();
        r0_req = 1; r0_lock = 1; r0_addr = 32'h3;
        r1_req = 1; r1_addr = 32'h4;
        for (int b = 1; b <= 3; b++) begin
            r0_lock = (b < 3);
            #1;
            check("unlock_gnt0", r0_gnt, 1);
            check("unlock_gnt1", r1_gnt, 0);
            cyc();
        end
        #1;
        check("unlock_next_gnt1", r1_gnt, 1);
        check("unlock_next_gnt0", r0_gnt, 0);
        cyc();
        idle_inputs();

        // Ownership held without grant while owner pauses with lock high
        cyc();
        r0_req = 1; r0_lock = 1; r0_addr = 32'h5;
        #1;
        check("hold_beat1", r0_gnt, 1);
        cyc();
        r0_req = 0; r1_req = 1; r1_addr = 32'h6;
        #1;
        check("hold_gnt0", r0_gnt, 0);
        check("hold_gnt1", r1_gnt, 0);
        check("hold_en", mem_en, 0);
        cyc();
        r0_req = 1; r0_lock = 0;
        #1;
        check("hold_resume_gnt0", r0_gnt, 1);
        check("hold_resume_gnt1", r1_gnt, 0);
        cyc();
        r0_req = 0;
        #1;
        check("hold_after_gnt1", r1_gnt, 1);
        cyc();
        idle_inputs();

        // Reset in the middle of an r1 locked burst
        cyc();
        r1_req = 1; r1_lock = 1; r1_addr = 32'h7;
        #1;
        check("rst_burst_beat1", r1_gnt, 1);
        cyc();
        r0_req = 1; r0_addr = 32'h9;
        #1;
        check("rst_burst_beat2", r1_gnt, 1);
        check("rst_burst_rvalid1", r1_rvalid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_gnt1", r1_gnt, 0);
        check("rst_mid_gnt0", r0_gnt, 0);
        check("rst_mid_en", mem_en, 0);
        check("rst_mid_addr", mem_addr, 0);
        check("rst_mid_rvalid1", r1_rvalid, 0);
        cyc();
        check("rst_post_rvalid1", r1_rvalid, 0);
        check("rst_post_rvalid0", r0_rvalid, 0);
        r1_lock = 0;
        rst_n = 1'b1;
        #1;
        check("rst_rel_gnt0", r0_gnt, 1);
        check("rst_rel_gnt1", r1_gnt, 0);
        cyc();
        idle_inputs();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
